fpu_normalizer_seq: RTL and testbench

//  Multi-cycle successor to the combinational FPU normalizer. Takes a raw add/mul result
//  (carry, hidden, fraction, guard, round, sticky) and does three things:
//  - normalizes it, shifting left up to SHIFT_STEP bits per cycle;
//  - rounds it to nearest-even;
//  - flags overflow and underflow.

---
 rtl/fpu_normalizer_seq.sv | 158 +++++++++++++++
 tb/tb_fpu_normalizer_seq.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/fpu_normalizer_seq.sv
// Multi-cycle FPU normalizer: iterative left-normalize, round-to-nearest-even, overflow/underflow flags.
// Define FPU_NORM_ROUND_EN to enable rounding; otherwise the ROUND state truncates.
module fpu_normalizer_seq #(
    parameter int MANT_W     = 52,
    parameter int EXP_W      = 11,
    parameter int SHIFT_STEP = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MANT_W+3:0] in_mantissa,
    input  logic              in_sticky,
    input  logic [EXP_W-1:0]  in_exponent,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MANT_W-1:0] out_mantissa,
    output logic [EXP_W-1:0]  out_exponent,
    output logic              overflow,
    output logic              underflow
);
    typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_t;

    localparam logic [EXP_W:0] STEP_E = SHIFT_STEP[EXP_W:0];
    localparam logic [EXP_W:0] ONE_E  = {{EXP_W{1'b0}}, 1'b1};

    state_t              state_q, state_d;
    logic [MANT_W+3:0]   mant_q, mant_d;
    logic                sticky_q, sticky_d;
    logic [EXP_W-1:0]    exp_q, exp_d;
    logic                uf_q, uf_d;
    logic [MANT_W-1:0]   out_mant_q, out_mant_d;
    logic [EXP_W-1:0]    out_exp_q, out_exp_d;
    logic                ovf_q, ovf_d, unf_q, unf_d;

    logic [EXP_W:0]      lz, shamt, exp_plus;
    logic [EXP_W-1:0]    exp_inc, rnd_exp;
    logic                found, inc, ovf_now;
    logic [MANT_W+1:0]   rnd_sum;
    logic [MANT_W-1:0]   rnd_frac;

    // Leading zeros counted from the hidden position down through guard/round.
    always_comb begin
        lz    = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < MANT_W + 3; i++) begin
            if (!found) begin
                if (mant_q[MANT_W+2-i]) found = 1'b1;
                else                    lz    = lz + ONE_E;
            end
        end
        shamt = lz;
        if (STEP_E < shamt)          shamt = STEP_E;
        if ({1'b0, exp_q} < shamt)   shamt = {1'b0, exp_q};
    end

    always_comb begin
        exp_plus = {1'b0, exp_q} + ONE_E;
        exp_inc  = exp_plus[EXP_W] ? '1 : exp_plus[EXP_W-1:0];
`ifdef FPU_NORM_ROUND_EN
        inc = mant_q[1] & (mant_q[0] | sticky_q | mant_q[2]);
`else
        inc = 1'b0;
`endif
        rnd_sum  = mant_q[MANT_W+3:2] + {{(MANT_W+1){1'b0}}, inc};
        rnd_frac = rnd_sum[MANT_W+1] ? rnd_sum[MANT_W:1] : rnd_sum[MANT_W-1:0];
        rnd_exp  = rnd_sum[MANT_W+1] ? exp_inc : exp_q;
        ovf_now  = (rnd_exp == '1);
    end

    always_comb begin
        state_d    = state_q;
        mant_d     = mant_q;
        sticky_d   = sticky_q;
        exp_d      = exp_q;
        uf_d       = uf_q;
        out_mant_d = out_mant_q;
        out_exp_d  = out_exp_q;
        ovf_d      = ovf_q;
        unf_d      = unf_q;
        in_ready   = (state_q == IDLE);
        out_valid  = (state_q == DONE);
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mant_d   = in_mantissa;
                    sticky_d = in_sticky;
                    exp_d    = in_exponent;
                    uf_d     = 1'b0;
                    ovf_d    = 1'b0;
                    unf_d    = 1'b0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                if (mant_q[MANT_W+3]) begin
                    mant_d   = mant_q >> 1;
                    sticky_d = sticky_q | mant_q[0];
                    exp_d    = exp_inc;
                    state_d  = ROUND;
                end else if (mant_q == '0) begin
                    exp_d      = '0;
                    out_mant_d = '0;
                    out_exp_d  = '0;
                    state_d    = DONE;
                end else if (mant_q[MANT_W+2]) begin
                    state_d = ROUND;
                end else if (exp_q == '0) begin
                    uf_d    = 1'b1;
                    state_d = ROUND;
                end else begin
                    mant_d = mant_q << shamt;
                    exp_d  = exp_q - shamt[EXP_W-1:0];
                end
            end
            ROUND: begin
                out_mant_d = ovf_now ? '0 : rnd_frac;
                out_exp_d  = rnd_exp;
                ovf_d      = ovf_now;
                unf_d      = uf_q && (rnd_exp == '0);
                state_d    = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            mant_q     <= '0;
            sticky_q   <= 1'b0;
            exp_q      <= '0;
            uf_q       <= 1'b0;
            out_mant_q <= '0;
            out_exp_q  <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            mant_q     <= mant_d;
            sticky_q   <= sticky_d;
            exp_q      <= exp_d;
            uf_q       <= uf_d;
            out_mant_q <= out_mant_d;
            out_exp_q  <= out_exp_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    assign out_mantissa = out_mant_q;
    assign out_exponent = out_exp_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;
endmodule

// File: tb/tb_fpu_normalizer_seq.sv
// Self-checking bench for fpu_normalizer_seq: directed vectors against an arithmetic reference model.
module tb_fpu_normalizer_seq;
    typedef struct {
        longint unsigned frac;
        int              ex;
        bit              ovf;
        bit              unf;
        int              lat;
    } res_t;

`ifdef FPU_NORM_ROUND_EN
    localparam bit RND_ON = 1'b1;
`else
    localparam bit RND_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [55:0] in_mantissa = '0;
    logic        in_sticky = 1'b0;
    logic [10:0] in_exponent = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [51:0] out_mantissa;
    logic [10:0] out_exponent;
    logic        overflow, underflow;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    res_t exq[$];

    fpu_normalizer_seq #(.MANT_W(52), .EXP_W(11), .SHIFT_STEP(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_mantissa(in_mantissa), .in_sticky(in_sticky), .in_exponent(in_exponent),
        .out_valid(out_valid), .out_ready(out_ready), .out_mantissa(out_mantissa),
        .out_exponent(out_exponent), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint unsigned act, input longint unsigned req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Reference: normalize in one step, then count how many SHIFT cycles the step size implies.
    function automatic res_t model(input logic [55:0] m_in, input logic st_in, input logic [10:0] e_in);
        res_t        r;
        logic [55:0] m = m_in;
        logic [54:0] f;
        bit          st = st_in;
        int          e = int'(e_in);
        bit          uf = 1'b0;
        int          p = 0;
        int          lz;
        r.lat = 0;
        if (m == 0) begin
            r.frac = 0; r.ex = 0; r.ovf = 0; r.unf = 0; r.lat = 1;
            return r;
        end
        if (m[55]) begin
            st = st | m[0];
            m  = m >> 1;
            e  = (e + 1 > 2047) ? 2047 : e + 1;
            r.lat = 2;
        end else begin
            for (int i = 54; i >= 0; i--) if (m[i]) begin p = i; break; end
            lz = 54 - p;
            if (lz <= e) begin
                m = m << lz; r.lat = (lz + 7) / 8 + 2; e = e - lz;
            end else begin
                m = m << e;  r.lat = (e + 7) / 8 + 2;  e = 0; uf = 1'b1;
            end
        end
        f = {1'b0, m[55:2]};
        if (RND_ON && m[1] && (m[0] || st || m[2])) f = f + 55'd1;
        if (f[54]) begin
            f = f >> 1;
            e = (e + 1 > 2047) ? 2047 : e + 1;
        end
        r.ovf  = (e == 2047);
        r.ex   = e;
        r.frac = r.ovf ? 64'd0 : {12'd0, f[51:0]};
        r.unf  = uf && (e == 0);
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exq.size() == 0) begin
                chk("unexpected_out_valid", 1, 0);
            end else begin
                chk("out_mantissa", out_mantissa, exq[0].frac);
                chk("out_exponent", out_exponent, longint'(exq[0].ex));
                chk("overflow", overflow, exq[0].ovf);
                chk("underflow", underflow, exq[0].unf);
                chk("in_ready_in_done", in_ready, 0);
                if (out_ready) void'(exq.pop_front());
            end
        end
    end

    task automatic run_word(input logic [55:0] m, input logic st, input logic [10:0] e, input int hold,
                            input bit pin, input logic [51:0] lm, input logic [10:0] le,
                            input bit lo, input bit lu);
        res_t r;
        int   w;
        int   acc;
        r = model(m, st, e);
        if (pin) begin
            chk("model_mant", r.frac, lm);
            chk("model_exp", longint'(r.ex), le);
            chk("model_ovf", r.ovf, lo);
            chk("model_unf", r.unf, lu);
        end
        w = 0;
        while (!in_ready && w < 200) begin @(posedge clk); #1; w++; end
        if (!in_ready) begin chk("in_ready_timeout", 0, 1); return; end
        in_mantissa = m; in_sticky = st; in_exponent = e; in_valid = 1'b1;
        exq.push_back(r);
        @(posedge clk); #1;
        acc = cyc;
        in_valid = 1'b0;
        chk("in_ready_after_accept", in_ready, 0);
        w = 0;
        while (!out_valid && w < 200) begin @(posedge clk); #1; w++; end
        if (!out_valid) begin chk("out_valid_timeout", 0, 1); exq.delete(); return; end
        chk("latency", longint'(cyc - acc), longint'(r.lat));
        repeat (hold) begin @(posedge clk); #1; end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("out_valid_drop", out_valid, 0);
        chk("in_ready_back", in_ready, 1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_mant", out_mantissa, 0);
        chk("rst_exp", out_exponent, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_unf", underflow, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_word(56'h80000000000000, 1'b0, 11'h3FF, 0, 1, 52'h0, 11'h400, 0, 0);
        run_word(56'h00000400000000, 1'b0, 11'h3FF, 0, 1, 52'h0, 11'h3EB, 0, 0);
`ifdef FPU_NORM_ROUND_EN
        run_word(56'h7FFFFFFFFFFFFE, 1'b0, 11'h3FF, 0, 1, 52'h0, 11'h400, 0, 0);
`else
        run_word(56'h7FFFFFFFFFFFFE, 1'b0, 11'h3FF, 0, 1, 52'hFFFFFFFFFFFFF, 11'h3FF, 0, 0);
`endif
        run_word(56'h00000400000000, 1'b0, 11'h005, 0, 1, 52'h0002000000000, 11'h000, 0, 1);
        run_word(56'h80000000000000, 1'b0, 11'h7FE, 0, 1, 52'h0, 11'h7FF, 1, 0);

        // Tie cases, carry into sticky, denormals, exact shift-to-zero, saturated input exponent.
        run_word(56'h40000000000002, 1'b0, 11'h100, 0, 0, '0, '0, 0, 0);
        run_word(56'h40000000000002, 1'b1, 11'h100, 0, 0, '0, '0, 0, 0);
        run_word(56'h40000000000006, 1'b0, 11'h100, 0, 0, '0, '0, 0, 0);
        run_word(56'h80000000000005, 1'b0, 11'h200, 0, 0, '0, '0, 0, 0);
        run_word(56'h00010000000000, 1'b0, 11'h000, 0, 0, '0, '0, 0, 0);
        run_word(56'h00001000000000, 1'b0, 11'h00A, 0, 0, '0, '0, 0, 0);
        run_word(56'h00000000000001, 1'b0, 11'h3FF, 0, 0, '0, '0, 0, 0);
        run_word(56'h400000000C0E46, 1'b0, 11'h7FF, 0, 0, '0, '0, 0, 0);
        run_word(56'h000003FFFFFFFF, 1'b1, 11'h003, 0, 0, '0, '0, 0, 0);

        run_word(56'h00000012345678, 1'b1, 11'h300, 5, 0, '0, '0, 0, 0);

        begin
            int w = 0;
            while (!in_ready && w < 200) begin @(posedge clk); #1; w++; end
            chk("pre_reset_in_ready", in_ready, 1);
            in_mantissa = 56'h00000000000001; in_sticky = 1'b0; in_exponent = 11'h3FF; in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            @(posedge clk); #1;
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            chk("midrst_out_valid", out_valid, 0);
            chk("midrst_in_ready", in_ready, 1);
            chk("midrst_mant", out_mantissa, 0);
            chk("midrst_exp", out_exponent, 0);
        end

        run_word(56'h00000000000000, 1'b1, 11'h123, 0, 1, 52'h0, 11'h000, 0, 0);

        chk("queue_empty", longint'(exq.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
